mux_8_1_rr_scheduler: RTL
=========================

Name: mux_8_1_rr_scheduler

Overview:
- Round-robin scheduler that shares one 8:1 single-bit mux between 8 requesters.
- Drives the mux select and tri-state enable directly.
- Holds each grant for a bounded burst, then inserts a bus-turnaround gap so no two sources drive the shared output back-to-back.
- Sits between requester front-ends and the 8:1 mux instance.

Parameters:
- MAX_BURST, 16, maximum cycles a single grant may last; legal range 1..256.
- GAP_CYCLES, 1, Enable-low turnaround cycles after each grant; legal range 0..15.

Ports:
- Clock_In  in  1  system clock; all state updates on rising edge.
- Reset_In  in  1  asynchronous, active-high reset.
- Request_In  in  8  bit i = requester i wants the mux; level-sensitive.
- Grant_Out  out  8  one-hot current grant; all-zero when no grant.
- Select_Out  out  3  mux select = index of granted requester.
- Enable_Out  out  1  mux enable; high only while a grant is active.
- Grant_Done_Out  out  1  one-cycle pulse on the cycle after a grant ends.
- Busy_Out  out  1  high in GRANT or GAP.

Behaviour:
- Interface: one clock (Clock_In); reset (Reset_In) is asynchronous and active-high.
- All outputs are registered.
- Reset values:
  - State=IDLE.
  - Grant_Out=8'h00, Select_Out=3'd0, Enable_Out=0, Grant_Done_Out=0, Busy_Out=0.
  - Priority pointer=0, burst counter=0, gap counter=0.
- Assertion of Reset_In at any point, including mid-grant, returns all state and outputs to reset values immediately; no Grant_Done_Out pulse is issued.
- IDLE:
  - If Request_In != 0 at a clock edge, pick the first set bit searching from pointer upward, modulo 8.
  - Next state is GRANT. Grant_Out=onehot(idx), Select_Out=idx, Enable_Out=1, Busy_Out=1, burst counter=0.
  - Latency from request sampled to Enable_Out high is 1 cycle.
  - If Request_In == 0, stay in IDLE.
- GRANT:
  - On each edge, if Request_In[idx]==0 or burst counter==MAX_BURST-1, release; otherwise increment the burst counter.
  - A grant therefore lasts at least 1 and at most MAX_BURST cycles.
  - Requests from other indices never preempt the current grant.
- Release (taken on the releasing edge):
  - Grant_Out=0, Enable_Out=0, Grant_Done_Out=1 for one cycle, pointer=(idx+1) mod 8.
  - Select_Out holds idx.
  - If GAP_CYCLES>0: go to GAP with gap counter=0. Otherwise go to IDLE.
- GAP:
  - Enable_Out=0 and Busy_Out=1.
  - Gap counter increments each cycle. When it reaches GAP_CYCLES-1, go to IDLE (Busy_Out=0).
  - Request_In is ignored during GAP.
- Fairness: a continuously requesting source waits at most 7 grants.
- Pointer wrap: after a grant to 7, the pointer becomes 0.
- Simultaneous events: a release caused by the request dropping on the same edge the burst limit is hit produces a single release and a single Grant_Done_Out pulse.
- Request_In changes for other indices during GRANT or GAP have no effect until IDLE arbitration.
- Invariant: Enable_Out==|Grant_Out at all times.
- Invariant: Select_Out only changes on the edge entering GRANT.

Decomposition:
- Package mux_sched_pkg holds:
  - NUM_REQ=8 and SEL_W=3.
  - State enum IDLE/GRANT/GAP, 2-bit encoding 0/1/2.
  - Counter width function, clog2-based.
- Sub-module rr_priority_picker: combinational. Inputs are an 8-bit request vector and a 3-bit pointer. Outputs are a valid flag and a 3-bit index, produced by rotate, priority-encode and un-rotate.

Test Plan:
- Reset checks:
  - Reset_In=1, Request_In=8'hFF: every output is at its reset value.
  - Release reset with Request_In=8'h01: Grant_Out=8'h01, Select_Out=0, Enable_Out=1 one cycle after the first sampling edge.
- Round-robin order: Request_In=8'h81 held, MAX_BURST=4, GAP_CYCLES=1.
  - Grants alternate 0,7,0,7..., each exactly 4 cycles.
  - Each grant is followed by 1 Enable-low gap cycle and 1 IDLE cycle.
  - Grant_Done_Out pulses once per grant.
- Early release: grant idx 3, drop Request_In[3] after 2 cycles.
  - Enable_Out falls on the next edge; grant length=3 cycles.
  - Pointer becomes 4: with Request_In=8'h09 the next grant goes to idx 3? No — pointer 4 searches 4..7 then 0..2, so the next grant is idx 0.
- Pointer wrap: pointer 7 with Request_In=8'h06 -> grant idx 1; pointer then 2 -> next grant idx 2.
- Reset mid-grant: assert Reset_In during cycle 2 of a grant.
  - Outputs clear asynchronously with no Grant_Done_Out pulse.
  - After release of reset, Request_In=8'h20 is granted idx 5.
- GAP_CYCLES=0 and MAX_BURST=1 with Request_In=8'hFF:
  - Grants 0,1,...,7,0, each 1 cycle long with a 1-cycle IDLE bubble between grants.
  - Enable_Out is never high in two consecutive cycles.

Source files
------------

// File: rtl/mux_sched_pkg.sv
// mux_sched_pkg: shared sizes, state encoding and counter-width helper for the 8:1 mux scheduler
package mux_sched_pkg;
    localparam int NUM_REQ = 8;
    localparam int SEL_W = 3;
    typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, GAP = 2'd2} state_e;
    // Bits needed to count 0..n-1, never less than one
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/rr_priority_picker.sv
// rr_priority_picker: combinational round-robin pick of the first request at or above the pointer
module rr_priority_picker
    import mux_sched_pkg::*;
(
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [SEL_W-1:0]   ptr_i,
    output logic               valid_o,
    output logic [SEL_W-1:0]   idx_o
);
    logic [NUM_REQ-1:0] rot;
    logic [SEL_W-1:0]   off;
    // Rotate so the pointer lands on bit 0, then find the lowest set bit
    always_comb begin
        rot = '0;
        off = '0;
        for (int i = 0; i < NUM_REQ; i++) rot[i] = req_i[ptr_i + SEL_W'(i)];
        for (int i = NUM_REQ - 1; i >= 0; i--) if (rot[i]) off = SEL_W'(i);
    end
    assign valid_o = |req_i;
    assign idx_o = ptr_i + off;
endmodule

// File: rtl/mux_8_1_rr_scheduler.sv
// mux_8_1_rr_scheduler: round-robin owner of a shared 8:1 mux with bounded bursts and turnaround gaps
module mux_8_1_rr_scheduler
    import mux_sched_pkg::*;
#(
    parameter int MAX_BURST  = 16,
    parameter int GAP_CYCLES = 1
) (
    input  logic               Clock_In,
    input  logic               Reset_In,
    input  logic [NUM_REQ-1:0] Request_In,
    output logic [NUM_REQ-1:0] Grant_Out,
    output logic [SEL_W-1:0]   Select_Out,
    output logic               Enable_Out,
    output logic               Grant_Done_Out,
    output logic               Busy_Out
);
    localparam int BW = cnt_w(MAX_BURST);
    localparam int GW = cnt_w(GAP_CYCLES);
    localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

    state_e             state_q;
    logic [NUM_REQ-1:0] grant_q;
    logic [SEL_W-1:0]   sel_q;
    logic [SEL_W-1:0]   ptr_q;
    logic [BW-1:0]      burst_q;
    logic [GW-1:0]      gap_q;
    logic               en_q;
    logic               done_q;
    logic               busy_q;
    logic               pick_valid;
    logic [SEL_W-1:0]   pick_idx;

    rr_priority_picker u_picker (
        .req_i   (Request_In),
        .ptr_i   (ptr_q),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

    // Scheduler FSM; every output is a register updated alongside the state
    always_ff @(posedge Clock_In or posedge Reset_In) begin
        if (Reset_In) begin
            state_q <= IDLE;
            grant_q <= '0;
            sel_q   <= '0;
            ptr_q   <= '0;
            burst_q <= '0;
            gap_q   <= '0;
            en_q    <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (pick_valid) begin
                    state_q <= GRANT;
                    grant_q <= NUM_REQ'(1) << pick_idx;
                    sel_q   <= pick_idx;
                    en_q    <= 1'b1;
                    busy_q  <= 1'b1;
                    burst_q <= '0;
                end
                GRANT: if (!Request_In[sel_q] || burst_q == BURST_LAST) begin
                    grant_q <= '0;
                    en_q    <= 1'b0;
                    done_q  <= 1'b1;
                    ptr_q   <= sel_q + 1'b1;
                    if (GAP_CYCLES > 0) begin
                        state_q <= GAP;
                        gap_q   <= '0;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end else begin
                    burst_q <= burst_q + 1'b1;
                end
                GAP: if (gap_q == GAP_LAST) begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end else begin
                    gap_q <= gap_q + 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign Grant_Out      = grant_q;
    assign Select_Out     = sel_q;
    assign Enable_Out     = en_q;
    assign Grant_Done_Out = done_q;
    assign Busy_Out       = busy_q;
endmodule
